serial_addsub_digit: RTL and testbench
======================================

// Module: serial_addsub_digit
// PURPOSE
//  Digit-serial two's-complement adder/subtractor: generalises the bit-serial adder to DIGIT_W bits/cycle and
//  NUM_DIGITS-digit words, with add/sub mode, word framing, valid/ready backpressure and carry/overflow flags.
//  Sits between serialising front-ends and digit-serial sinks in the sequential arithmetic datapath.
// PARAMETERS
//  DIGIT_W     1  bits per digit (>=1); DIGIT_W=1 is a classic bit-serial adder
//  NUM_DIGITS  8  digits per word (>=1), least-significant digit first
// PORTS
//  clk        in   1        clock
//  rst        in   1        reset, asynchronous, active-low
//  in_valid   in   1        input digit valid
//  in_ready   out  1        block accepts digit this cycle
//  in_first   in   1        digit is LSD of a new word
//  in_sub     in   1        mode, sampled with in_first: 0 = a+b, 1 = a-b; ignored on other digits
//  in_a       in   DIGIT_W  operand A digit
//  in_b       in   DIGIT_W  operand B digit
//  out_valid  out  1        output digit valid
//  out_ready  in   1        sink accepts output digit
//  out_digit  out  DIGIT_W  result digit
//  out_last   out  1        result digit is MSD of word
//  out_carry  out  1        final carry out of MSB (sub: 1 = no borrow); meaningful only with out_last
//  out_ovf    out  1        signed overflow of word; meaningful only with out_last
//  out_err    out  1        one-cycle pulse: framing error
// BEHAVIOUR
//  - Reset (rst=0, async): out_valid=0, out_digit=0, out_last=0, out_carry=0, out_ovf=0, out_err=0,
//    carry=0, digit counter=0, state=IDLE, mode=add. Reset mid-word discards the word, no output.
//  - Accept: in_valid & in_ready. in_ready = !out_valid | out_ready (single registered output stage, no bubble).
//  - FSM IDLE: accepted digit with in_first -> RUN, cnt=1 (or stays IDLE with out_last if NUM_DIGITS=1).
//    Accepted digit without in_first -> dropped, out_err pulses next cycle, no output.
//  - FSM RUN: each accepted digit increments cnt; digit cnt==NUM_DIGITS-1 produces out_last, -> IDLE, cnt=0.
//    Accepted in_first while RUN: partial word abandoned, out_err pulses, digit treated as LSD of new word.
//  - Digit arithmetic: bx = in_b ^ {DIGIT_W{sub}}; cin = in_first ? in_sub : carry;
//    {cout, digit} = in_a + bx + cin (DIGIT_W+1 bits, modulo); carry <= cout on accept.
//    sub = in_sub on first digit, latched mode register thereafter.
//  - Flags on last digit: out_carry = cout; out_ovf = cout ^ carry into digit MSB.
//    Non-last digits drive out_carry=0, out_ovf=0.
//  - Latency: 1 cycle from accept to out_valid. Throughput: 1 digit/cycle when out_ready=1.
//  - Backpressure: while out_valid & !out_ready, all out_* held stable; carry/cnt/mode do not advance.
//  - in_first and in_valid low: no state change. out_err independent of out_ready (not held).
// STRUCTURE
//  - Package serial_arith_pkg: typedef enum logic {MODE_ADD, MODE_SUB} mode_e; state enum {IDLE, RUN};
//    default DIGIT_W/NUM_DIGITS localparams shared with serialiser blocks.
//  - Sub-module digit_full_adder #(DIGIT_W): ripple chain of 1-bit full adders written with ^ & | ~ only;
//    outputs sum, cout, c_msb (carry into MSB). Top holds FSM, counter ($clog2(NUM_DIGITS) bits, min 1),
//    carry/mode regs and output register.
// TESTING
//  - DIGIT_W=4, NUM_DIGITS=2, add 0x3C+0x47: a digits C,3 / b 7,4 -> out 3,8 (0x83), out_carry=0, out_ovf=1.
//  - Same, sub 0x10-0x01: a 0,1 / b 1,0 -> out F,0 (0x0F), out_carry=1, out_ovf=0.
//  - Same, add 0xFF+0x01 -> out 0,0, out_carry=1, out_ovf=0; next word 0x7F+0x01 -> 0x80, out_ovf=1.
//  - DIGIT_W=1, NUM_DIGITS=16: a=16'h8192, b=16'h2154 LSB-first, back-to-back words -> 16'hA2E6 bit-serial,
//    carry cleared on each in_first (no carry leak between words).
//  - Hold out_ready=0 for 3 cycles mid-word -> in_ready=0, out_digit/out_last stable, result unchanged.
//  - in_first on digit 2 of word, digit without in_first in IDLE, rst low mid-word -> out_err pulse, new word
//    correct; dropped digit produces no output; after reset all outputs 0 and next word correct.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared types and default sizes for the digit-serial arithmetic datapath
//
// Purpose: operand mode and FSM state enums, plus the default digit width and
// word length shared with the serialiser blocks that feed this datapath.
// Ports: none (package).
package serial_arith_pkg;

  typedef enum logic {MODE_ADD, MODE_SUB} mode_e;
  typedef enum logic {IDLE, RUN} state_e;

  localparam int DEF_DIGIT_W    = 1;
  localparam int DEF_NUM_DIGITS = 8;

endpackage

// File: rtl/digit_full_adder.sv
// rtl/digit_full_adder.sv - ripple-carry full adder across one digit
//
// Purpose: adds two DIGIT_W-bit digits plus a carry-in using a chain of 1-bit
// full adders built from plain gates.
// Ports:
//   a, b   in   DIGIT_W  digit operands (b already conditioned for subtract)
//   cin    in   1        carry into bit 0
//   sum    out  DIGIT_W  digit sum
//   cout   out  1        carry out of the MSB
//   c_msb  out  1        carry into the MSB (for signed overflow)
module digit_full_adder #(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] sum,
  output logic               cout,
  output logic               c_msb
);

  // The carry is walked through a local variable rather than a vector of
  // per-bit carries so the chain does not form a self-referencing net.
  always_comb begin
    logic c;
    sum   = '0;
    c     = cin;
    c_msb = cin;
    for (int i = 0; i < DIGIT_W; i++) begin
      c_msb  = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_addsub_digit.sv
// rtl/serial_addsub_digit.sv - digit-serial two's-complement adder/subtractor with framing and flags
//
// Purpose: adds or subtracts NUM_DIGITS-digit words presented LSD first,
// DIGIT_W bits per cycle, through one registered output stage with
// valid/ready flow control. Reports final carry and signed overflow on the
// last digit and pulses out_err on framing errors.
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   in_valid/in_ready      input digit handshake
//   in_first, in_sub       LSD marker and mode (mode sampled with in_first)
//   in_a, in_b             operand digits
//   out_valid/out_ready    output digit handshake
//   out_digit, out_last    result digit and MSD marker
//   out_carry, out_ovf     final carry / signed overflow, valid with out_last
//   out_err                one-cycle framing error pulse
module serial_addsub_digit
  import serial_arith_pkg::*;
#(
  parameter int DIGIT_W    = DEF_DIGIT_W,
  parameter int NUM_DIGITS = DEF_NUM_DIGITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_first,
  input  logic               in_sub,
  input  logic [DIGIT_W-1:0] in_a,
  input  logic [DIGIT_W-1:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DIGIT_W-1:0] out_digit,
  output logic               out_last,
  output logic               out_carry,
  output logic               out_ovf,
  output logic               out_err
);

  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_DIGITS - 1);

  state_e             state;
  mode_e              mode;
  logic               carry;
  logic [CNT_W-1:0]   cnt;

  logic               accept;
  logic               sub_eff;
  logic               cin;
  logic [DIGIT_W-1:0] bx;
  logic [DIGIT_W-1:0] sum;
  logic               cout;
  logic               c_msb;
  logic [CNT_W-1:0]   pos;
  logic               is_last;
  logic               dropped;
  logic               abandon;

  // The output register can take a new digit whenever it is empty or being
  // drained this cycle, so a steady stream flows without bubbles.
  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // An LSD starts a fresh word: mode and carry-in come straight from the
  // input so nothing from a previous (or abandoned) word leaks in.
  assign sub_eff = in_first ? in_sub : (mode == MODE_SUB);
  assign cin     = in_first ? in_sub : carry;
  assign bx      = in_b ^ {DIGIT_W{sub_eff}};

  digit_full_adder #(.DIGIT_W(DIGIT_W)) u_adder (
    .a     (in_a),
    .b     (bx),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout),
    .c_msb (c_msb)
  );

  assign pos     = in_first ? '0 : cnt;
  assign is_last = (pos == LAST_IDX);
  assign dropped = (state == IDLE) & !in_first;
  assign abandon = (state == RUN) & in_first;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mode      <= MODE_ADD;
      carry     <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_digit <= '0;
      out_last  <= 1'b0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      out_err <= accept & (dropped | abandon);
      if (accept & !dropped) begin
        out_valid <= 1'b1;
        out_digit <= sum;
        out_last  <= is_last;
        out_carry <= is_last & cout;
        out_ovf   <= is_last & (cout ^ c_msb);
        carry     <= cout;
        if (in_first) begin
          mode <= in_sub ? MODE_SUB : MODE_ADD;
        end
        if (is_last) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          state <= RUN;
          cnt   <= pos + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_digit.sv
// tb/tb_serial_addsub_digit.sv - randomized self-checking bench for serial_addsub_digit
module tb_serial_addsub_digit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic out_ready = 1'b1;
  int   bp_mode = 0;   // 0: always ready, 1: random, 2: held low

  logic       u4_in_valid = 0, u4_in_first = 0, u4_in_sub = 0;
  logic [3:0] u4_in_a = 0, u4_in_b = 0;
  logic       u4_in_ready, u4_out_valid, u4_out_last, u4_out_carry, u4_out_ovf, u4_out_err;
  logic [3:0] u4_out_digit;

  logic       u1_in_valid = 0, u1_in_first = 0, u1_in_sub = 0;
  logic [0:0] u1_in_a = 0, u1_in_b = 0;
  logic       u1_in_ready, u1_out_valid, u1_out_last, u1_out_carry, u1_out_ovf, u1_out_err;
  logic [0:0] u1_out_digit;

  int n_checks = 0;
  int n_fail   = 0;

  logic [33:0] exp4_q[$];
  logic [33:0] exp1_q[$];
  int          idx4 = 0, idx1 = 0, dig_cnt4 = 0, err_cnt4 = 0, err_cnt1 = 0;
  logic [31:0] acc4 = 0, acc1 = 0;
  logic        restart4 = 0, restart1 = 0;
  int          exp_err4 = 0;

  serial_addsub_digit #(.DIGIT_W(4), .NUM_DIGITS(2)) u4 (
    .clk(clk), .rst(rst), .in_valid(u4_in_valid), .in_ready(u4_in_ready),
    .in_first(u4_in_first), .in_sub(u4_in_sub), .in_a(u4_in_a), .in_b(u4_in_b),
    .out_valid(u4_out_valid), .out_ready(out_ready), .out_digit(u4_out_digit),
    .out_last(u4_out_last), .out_carry(u4_out_carry), .out_ovf(u4_out_ovf), .out_err(u4_out_err)
  );

  serial_addsub_digit #(.DIGIT_W(1), .NUM_DIGITS(16)) u1 (
    .clk(clk), .rst(rst), .in_valid(u1_in_valid), .in_ready(u1_in_ready),
    .in_first(u1_in_first), .in_sub(u1_in_sub), .in_a(u1_in_a), .in_b(u1_in_b),
    .out_valid(u1_out_valid), .out_ready(out_ready), .out_digit(u1_out_digit),
    .out_last(u1_out_last), .out_carry(u1_out_carry), .out_ovf(u1_out_ovf), .out_err(u1_out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Whole-word reference: {ovf, carry, result} from integer arithmetic.
  function automatic logic [33:0] ref_calc(input int wb, input logic [31:0] a,
                                           input logic [31:0] b, input logic sub);
    logic [63:0] mask, bb, full;
    logic [31:0] res;
    logic        cy, sa, sb, sr, ovf;
    mask = (64'd1 << wb) - 64'd1;
    bb   = sub ? (~{32'd0, b}) & mask : {32'd0, b};
    full = {32'd0, a} + bb + {63'd0, sub};
    res  = 32'(full & mask);
    cy   = full[wb];
    sa   = a[wb-1];
    sb   = b[wb-1];
    sr   = res[wb-1];
    ovf  = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return {ovf, cy, res};
  endfunction

  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Output monitors: reassemble words and compare against the expected queue.
  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst) begin
      idx4 = 0; acc4 = 0; restart4 = 0;
    end else begin
      if (u4_out_err) begin err_cnt4++; restart4 = 1; end
      if (u4_out_valid && out_ready) begin
        if (restart4) begin idx4 = 0; acc4 = 0; restart4 = 0; end
        dig_cnt4++;
        acc4 = acc4 | (32'(u4_out_digit) << (4 * idx4));
        if (u4_out_last) begin
          check("w4_last_pos", idx4, 1);
          check("w4_exp_pending", 32'(exp4_q.size() != 0), 1);
          if (exp4_q.size() != 0) begin
            e = exp4_q.pop_front();
            check("w4_result", acc4, e[31:0]);
            check("w4_carry", 32'(u4_out_carry), 32'(e[32]));
            check("w4_ovf", 32'(u4_out_ovf), 32'(e[33]));
          end
          idx4 = 0; acc4 = 0;
        end else begin
          check("w4_flags_nonlast", {30'd0, u4_out_carry, u4_out_ovf}, 0);
          idx4++;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst) begin
      idx1 = 0; acc1 = 0; restart1 = 0;
    end else begin
      if (u1_out_err) begin err_cnt1++; restart1 = 1; end
      if (u1_out_valid && out_ready) begin
        if (restart1) begin idx1 = 0; acc1 = 0; restart1 = 0; end
        acc1 = acc1 | (32'(u1_out_digit) << idx1);
        if (u1_out_last) begin
          check("w1_last_pos", idx1, 15);
          check("w1_exp_pending", 32'(exp1_q.size() != 0), 1);
          if (exp1_q.size() != 0) begin
            e = exp1_q.pop_front();
            check("w1_result", acc1, e[31:0]);
            check("w1_carry", 32'(u1_out_carry), 32'(e[32]));
            check("w1_ovf", 32'(u1_out_ovf), 32'(e[33]));
          end
          idx1 = 0; acc1 = 0;
        end else begin
          if (u1_out_carry || u1_out_ovf) check("w1_flags_nonlast", {30'd0, u1_out_carry, u1_out_ovf}, 0);
          idx1++;
        end
      end
    end
  end

  task automatic put4(input logic first, input logic sub, input logic [3:0] a, input logic [3:0] b);
    logic r;
    u4_in_valid = 1; u4_in_first = first; u4_in_sub = sub; u4_in_a = a; u4_in_b = b;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk); r = u4_in_ready;
      @(posedge clk); #2;
      if (r) return;
    end
    check("w4_accept_timeout", 0, 1);
  endtask

  task automatic put1(input logic first, input logic sub, input logic a, input logic b);
    logic r;
    u1_in_valid = 1; u1_in_first = first; u1_in_sub = sub; u1_in_a = a; u1_in_b = b;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk); r = u1_in_ready;
      @(posedge clk); #2;
      if (r) return;
    end
    check("w1_accept_timeout", 0, 1);
  endtask

  task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic sub);
    exp4_q.push_back(ref_calc(8, 32'(a), 32'(b), sub));
    put4(1'b1, sub, a[3:0], b[3:0]);
    put4(1'b0, ~sub, a[7:4], b[7:4]);  // mode bit on later digits must be ignored
  endtask

  task automatic send1(input logic [15:0] a, input logic [15:0] b, input logic sub);
    exp1_q.push_back(ref_calc(16, 32'(a), 32'(b), sub));
    for (int i = 0; i < 16; i++) put1(i == 0, (i == 0) ? sub : 1'($urandom_range(0, 1)), a[i], b[i]);
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 2000 && (exp4_q.size() != 0 || exp1_q.size() != 0); t++) @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    check(tag, exp4_q.size() + exp1_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    check("rst_u4_outs", 32'({u4_out_valid, u4_out_digit, u4_out_last, u4_out_carry, u4_out_ovf, u4_out_err}), 0);
    check("rst_u1_outs", 32'({u1_out_valid, u1_out_digit, u1_out_last, u1_out_carry, u1_out_ovf, u1_out_err}), 0);
  endtask

  initial begin
    logic [33:0] e;
    repeat (3) @(posedge clk);
    check_reset_outputs();
    @(posedge clk); #2; rst = 1;

    // Directed DIGIT_W=4 words, back to back.
    send4(8'h3C, 8'h47, 0);
    send4(8'h10, 8'h01, 1);
    send4(8'hFF, 8'h01, 0);
    send4(8'h7F, 8'h01, 0);
    u4_in_valid = 0;
    drain("w4_directed_drain");

    // Output stalled three cycles mid-word.
    bp_mode = 2;
    @(posedge clk); #2;
    e = ref_calc(8, 32'h5A, 32'h33, 0);
    exp4_q.push_back(e);
    put4(1, 0, 4'hA, 4'h3);
    u4_in_first = 0; u4_in_a = 4'h5; u4_in_b = 4'h3;
    repeat (3) begin
      @(negedge clk);
      check("hold_in_ready", 32'(u4_in_ready), 0);
      check("hold_out_valid", 32'(u4_out_valid), 1);
      check("hold_out_digit", 32'(u4_out_digit), 32'(e[3:0]));
      check("hold_out_last", 32'(u4_out_last), 0);
    end
    bp_mode = 0;
    @(posedge clk); #2;
    put4(0, 0, 4'h5, 4'h3);
    u4_in_valid = 0;
    drain("hold_drain");

    // in_first on digit 2 of a word: partial word abandoned.
    put4(1, 0, 4'h5, 4'h6);
    send4(8'h12, 8'h34, 0);
    exp_err4++;
    u4_in_valid = 0;
    drain("abandon_drain");
    check("abandon_err", err_cnt4, exp_err4);

    // Digit without in_first while idle: dropped.
    begin
      int d0;
      d0 = dig_cnt4;
      put4(0, 0, 4'h3, 4'h3);
      u4_in_valid = 0;
      exp_err4++;
      repeat (4) @(posedge clk);
      #2;
      check("drop_err", err_cnt4, exp_err4);
      check("drop_no_output", dig_cnt4, d0);
    end
    send4(8'h21, 8'h43, 1);
    u4_in_valid = 0;
    drain("after_drop_drain");

    // Reset mid-word.
    put4(1, 0, 4'h9, 4'h9);
    u4_in_valid = 0;
    rst = 0;
    check_reset_outputs();
    @(posedge clk); #2; rst = 1;
    send4(8'hC3, 8'h5E, 1);
    u4_in_valid = 0;
    drain("after_reset_drain");

    // Randomized DIGIT_W=4 words with random backpressure and gaps.
    bp_mode = 1;
    for (int w = 0; w < 30; w++) begin
      send4(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        u4_in_valid = 0;
        @(posedge clk); #2;
      end
    end
    u4_in_valid = 0;
    bp_mode = 0;
    drain("w4_random_drain");

    // Bit-serial words back to back, including carry-out followed by a new word.
    send1(16'h8192, 16'h2154, 0);
    send1(16'hFFFF, 16'h0001, 0);
    send1(16'h0000, 16'h0000, 0);
    send1(16'h0003, 16'h0005, 1);
    send1(16'h8000, 16'h0001, 1);
    u1_in_valid = 0;
    drain("w1_directed_drain");

    bp_mode = 1;
    for (int w = 0; w < 12; w++) begin
      send1(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        u1_in_valid = 0;
        @(posedge clk); #2;
      end
    end
    u1_in_valid = 0;
    bp_mode = 0;
    drain("w1_random_drain");

    check("w4_err_total", err_cnt4, exp_err4);
    check("w1_err_total", err_cnt1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
